// File: rtl/addsub_arb_2ch.sv
// addsub_arb_2ch: round-robin arbiter/sequencer sharing one 4-bit add/sub unit between two requesters
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready     : channel N request handshake (N = 0, 1)
//   reqN_a, reqN_b       : channel N 4-bit operands
//   reqN_sel             : channel N op, 0 = A+B, 1 = A-B
//   res_valid/res_ready  : result handshake
//   res_sum/carry/overflow/id : held result and the channel that issued it
//   op_count             : results accepted by the consumer, wraps

module AddSubCLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] sum,
    output logic       carry,
    output logic       overflow
);
    logic [3:0] w_bx, w_g, w_p;
    logic [4:0] w_c;
    assign w_bx = b ^ {4{sel}};
    assign w_g  = a & w_bx;
    assign w_p  = a ^ w_bx;
    assign w_c[0] = sel;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign sum      = w_p ^ w_c[3:0];
    assign carry    = w_c[4];
    assign overflow = w_c[4] ^ w_c[3];
endmodule

module addsub_arb_2ch #(
    parameter bit FIRST_PRI = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_sum,
    output logic             res_carry,
    output logic             res_overflow,
    output logic             res_id,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_a, r_b, r_res_sum;
    logic             r_sel, r_id, r_last, r_res_valid, r_res_carry, r_res_ovf, r_res_id;
    logic [CNT_W-1:0] r_cnt;
    logic             w_gid, w_gnt;
    logic [3:0]       w_sum;
    logic             w_carry, w_ovf;

    // Contention goes to the channel that did not win last; a lone requester always wins.
    assign w_gid = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    // Gating with reset keeps readies low while reset is held even though IDLE is forced.
    assign w_gnt = (r_state == IDLE) && (req0_valid || req1_valid) && !reset;
    assign req0_ready = w_gnt && !w_gid;
    assign req1_ready = w_gnt && w_gid;

    AddSubCLA_4bit u_alu (
        .a        (r_a),
        .b        (r_b),
        .sel      (r_sel),
        .sum      (w_sum),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_gnt ? EXEC : IDLE;
            EXEC:    w_next = HOLD;
            HOLD:    w_next = (r_res_valid && res_ready) ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= 1'b0;
            r_id        <= 1'b0;
            r_last      <= ~FIRST_PRI;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_carry <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_id    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            if (w_gnt) begin
                r_a    <= w_gid ? req1_a : req0_a;
                r_b    <= w_gid ? req1_b : req0_b;
                r_sel  <= w_gid ? req1_sel : req0_sel;
                r_id   <= w_gid;
                r_last <= w_gid;
            end
            if (r_state == EXEC) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= w_sum;
                r_res_carry <= w_carry;
                r_res_ovf   <= w_ovf;
                r_res_id    <= r_id;
            end
            if (r_state == HOLD && r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
                r_cnt       <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign res_valid    = r_res_valid;
    assign res_sum      = r_res_sum;
    assign res_carry    = r_res_carry;
    assign res_overflow = r_res_ovf;
    assign res_id       = r_res_id;
    assign op_count     = r_cnt;
endmodule

// File: tb/tb_addsub_arb_2ch.sv
// tb_addsub_arb_2ch: scoreboard bench for addsub_arb_2ch with directed, hand-computed vectors
module tb_addsub_arb_2ch;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_ready, req0_sel = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0;
    logic       req1_valid = 1'b0, req1_ready, req1_sel = 1'b0;
    logic [3:0] req1_a = '0, req1_b = '0;
    logic       res_valid, res_ready = 1'b1, res_carry, res_overflow, res_id;
    logic [3:0] res_sum;
    logic [1:0] op_count;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    logic [6:0] sb[$];
    bit seen = 1'b0;

    addsub_arb_2ch #(.FIRST_PRI(1'b0), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_carry(res_carry),
        .res_overflow(res_overflow), .res_id(res_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each new result ({sum,carry,ovf,id}) is compared against the oldest expectation.
    always @(negedge clk) begin
        if (res_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) chk("unexpected_result", 1, 0);
            else chk("result", int'({res_sum, res_carry, res_overflow, res_id}), int'(sb.pop_front()));
        end else if (!res_valid) seen = 1'b0;
    end

    function automatic bit rdy(input bit ch);
        return ch ? req1_ready : req0_ready;
    endfunction

    task automatic drive(input bit ch, input bit v, input logic [3:0] a, input logic [3:0] b, input bit sel);
        if (ch) begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; end
    endtask

    task automatic wait_grant(input bit ch);
        int n = 0;
        #1;
        while (!rdy(ch) && n < 20) begin @(negedge clk); #1; n++; end
        if (!rdy(ch)) chk("grant_timeout", 0, 1);
        @(posedge clk); #1;
        drive(ch, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic issue(input bit ch, input logic [3:0] a, input logic [3:0] b, input bit sel,
                         input logic [3:0] es, input bit ec, input bit ev);
        sb.push_back({es, ec, ev, ch});
        @(negedge clk);
        drive(ch, 1'b1, a, b, sel);
        wait_grant(ch);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(res_valid && res_ready) && n < 20) begin @(negedge clk); n++; end
        if (!(res_valid && res_ready)) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        exp_cnt = (exp_cnt + 1) % 4;
        chk("valid_drop", int'(res_valid), 0);
        chk("op_count", int'(op_count), exp_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        int done;
        // Reset state, readies must stay low with a request pending
        req0_valid = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_out", int'({res_sum, res_carry, res_overflow, res_id}), 0);
        chk("rst_cnt", int'(op_count), 0);
        req0_valid = 1'b0;
        reset = 1'b0;

        // 1: 1000 - 0001 = 0111, carry 1, ovf 1; ready one cycle, result after two edges
        sb.push_back({4'b0111, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1);
        #1;
        chk("t1_ready0", int'(req0_ready), 1);
        chk("t1_ready1", int'(req1_ready), 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("t1_exec_ready", int'(req0_ready), 0);
        chk("t1_exec_valid", int'(res_valid), 0);
        @(posedge clk); #1;
        chk("t1_hold_valid", int'(res_valid), 1);
        wait_done();

        // 2: simultaneous contention after reset, grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back({4'b1111, 1'b0, 1'b0, 1'b0});
            sb.push_back({4'b0101, 1'b1, 1'b1, 1'b1});
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1010, 4'b0101, 1'b0);
        drive(1'b1, 1'b1, 4'b1010, 4'b0101, 1'b1);
        done = 0;
        for (int n = 0; n < 40 && done < 4; n++) begin
            @(negedge clk); #1;
            if (req0_ready && req1_ready) chk("t2_onehot", 1, 0);
            if (res_valid && res_ready) done++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t2_done", done, 4);
        @(posedge clk); #1;
        chk("t2_cnt", int'(op_count), 0);

        // 3+4: backpressure on ch1 add 0010+1110, ch0 sub 0010-1110 waiting meanwhile
        res_ready = 1'b0;
        issue(1'b1, 4'b0010, 4'b1110, 1'b0, 4'b0000, 1'b1, 1'b0);
        sb.push_back({4'b0100, 1'b0, 1'b0, 1'b0});
        drive(1'b0, 1'b1, 4'b0010, 4'b1110, 1'b1);
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk); #1;
            chk("t3_valid", int'(res_valid), 1);
            chk("t3_sum_carry", int'({res_sum, res_carry}), 5'b00001);
            chk("t3_readies", int'({req0_ready, req1_ready}), 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_drop", int'(res_valid), 0);
        chk("t3_cnt", int'(op_count), 1);
        chk("t3_held_sum", int'(res_sum), 0);
        exp_cnt = 1;
        @(negedge clk);
        wait_grant(1'b0);
        wait_done();
        issue(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        wait_done();
        issue(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        wait_done();

        // 5: reset while in EXEC discards the request
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
        #1;
        chk("t5_ready", int'(req0_ready), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_ready", int'(req0_ready), 0);
        chk("t5_rst_cnt", int'(op_count), 0);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); #1;
            chk("t5_no_result", int'(res_valid), 0);
        end

        // 6: op_count 1,2,3,0,1 with CNT_W=2
        issue(1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        wait_done();
        issue(1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
        wait_done();
        issue(1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        wait_done();
        issue(1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        wait_done();
        issue(1'b1, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);
        wait_done();

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
